// File: rtl/pong_cmd_decoder_pkg.sv
// Shared constants for the Pong command link: packet header, command codes and
// decoder FSM states. The transmit-side packet builder uses the same values.
package pong_cmd_decoder_pkg;

  localparam logic [7:0] HDR   = 8'hA5;
  localparam logic [7:0] CMD_U = 8'h55;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] CMD_C = 8'h43;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_P = 8'h50;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_ARG  = 3'd2,
    ST_CHK  = 3'd3,
    ST_EXEC = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/pong_cmd_decoder.sv
// Frames 4-byte command packets (A5, cmd, arg, cmd^arg) from the serial byte
// receiver and applies them as Pong controls: paddle moves, serve and pause.
module pong_cmd_decoder
  import pong_cmd_decoder_pkg::*;
#(
  parameter int Y_W         = 10,
  parameter int PADDLE_MIN  = 0,
  parameter int PADDLE_MAX  = 420,
  parameter int PADDLE_INIT = 210,
  parameter int TIMEOUT     = 200
) (
  input  logic           bounderClock,
  input  logic           reset,
  input  logic [7:0]     rx_data,
  input  logic           rx_ready,
  output logic [Y_W-1:0] paddle_y,
  output logic           serve_pulse,
  output logic           paused,
  output logic           cmd_valid,
  output logic [7:0]     cmd_code,
  output logic [7:0]     err_count
);

  localparam logic [Y_W:0]   MIN_X  = (Y_W+1)'(PADDLE_MIN);
  localparam logic [Y_W:0]   MAX_X  = (Y_W+1)'(PADDLE_MAX);
  localparam logic [Y_W-1:0] INIT_Y = Y_W'(PADDLE_INIT);
  localparam logic [15:0]    TMO_LIM = 16'(TIMEOUT);

  state_t         state_reg, state_next;
  logic           ready_d;
  logic [7:0]     cmd_reg, cmd_next;
  logic [7:0]     arg_reg, arg_next;
  logic [15:0]    tmo_reg, tmo_next;
  logic [Y_W-1:0] paddle_reg, paddle_next;
  logic           paused_reg, paused_next;
  logic           serve_reg, serve_next;
  logic           valid_reg, valid_next;
  logic [7:0]     code_reg, code_next;
  logic [7:0]     err_reg, err_next;

  logic           timeout_hit;
  logic [Y_W:0]   arg_x, pad_x, up_raw, dn_raw, up_clamped, dn_clamped;
  logic           up_under;

  // Clamp in one extra bit so neither direction can wrap before saturating.
  assign arg_x      = {{(Y_W-7){1'b0}}, arg_reg};
  assign pad_x      = {1'b0, paddle_reg};
  assign up_raw     = pad_x - arg_x;
  assign up_under   = pad_x < (arg_x + MIN_X);
  assign up_clamped = up_under ? MIN_X : up_raw;
  assign dn_raw     = pad_x + arg_x;
  assign dn_clamped = (dn_raw > MAX_X) ? MAX_X : dn_raw;

  assign timeout_hit = (tmo_reg == TMO_LIM);

  always_comb begin
    state_next  = state_reg;
    cmd_next    = cmd_reg;
    arg_next    = arg_reg;
    tmo_next    = '0;
    paddle_next = paddle_reg;
    paused_next = paused_reg;
    serve_next  = 1'b0;
    valid_next  = 1'b0;
    code_next   = code_reg;
    err_next    = err_reg;

    // ready_d marks the cycle the receiver's data bus holds the new byte.
    if ((state_reg == ST_CMD || state_reg == ST_ARG || state_reg == ST_CHK)
        && !ready_d && !timeout_hit)
      tmo_next = tmo_reg + 16'd1;

    case (state_reg)
      ST_IDLE: begin
        if (ready_d && rx_data == HDR)
          state_next = ST_CMD;
      end
      ST_CMD: begin
        if (ready_d) begin
          cmd_next   = rx_data;
          state_next = ST_ARG;
        end else if (timeout_hit) begin
          err_next   = sat_inc(err_reg);
          state_next = ST_IDLE;
        end
      end
      ST_ARG: begin
        if (ready_d) begin
          arg_next   = rx_data;
          state_next = ST_CHK;
        end else if (timeout_hit) begin
          err_next   = sat_inc(err_reg);
          state_next = ST_IDLE;
        end
      end
      ST_CHK: begin
        if (ready_d) begin
          if (rx_data == (cmd_reg ^ arg_reg)) begin
            state_next = ST_EXEC;
          end else begin
            err_next   = sat_inc(err_reg);
            state_next = ST_IDLE;
          end
        end else if (timeout_hit) begin
          err_next   = sat_inc(err_reg);
          state_next = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_next = ST_IDLE;
        valid_next = 1'b1;
        code_next  = cmd_reg;
        case (cmd_reg)
          CMD_U:   paddle_next = up_clamped[Y_W-1:0];
          CMD_D:   paddle_next = dn_clamped[Y_W-1:0];
          CMD_C:   paddle_next = INIT_Y;
          CMD_S:   serve_next  = 1'b1;
          CMD_P:   paused_next = ~paused_reg;
          default: begin
            valid_next = 1'b0;
            code_next  = code_reg;
            err_next   = sat_inc(err_reg);
          end
        endcase
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge bounderClock or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      ready_d    <= 1'b0;
      cmd_reg    <= '0;
      arg_reg    <= '0;
      tmo_reg    <= '0;
      paddle_reg <= INIT_Y;
      paused_reg <= 1'b0;
      serve_reg  <= 1'b0;
      valid_reg  <= 1'b0;
      code_reg   <= '0;
      err_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ready_d    <= rx_ready;
      cmd_reg    <= cmd_next;
      arg_reg    <= arg_next;
      tmo_reg    <= tmo_next;
      paddle_reg <= paddle_next;
      paused_reg <= paused_next;
      serve_reg  <= serve_next;
      valid_reg  <= valid_next;
      code_reg   <= code_next;
      err_reg    <= err_next;
    end
  end

  assign paddle_y    = paddle_reg;
  assign serve_pulse = serve_reg;
  assign paused      = paused_reg;
  assign cmd_valid   = valid_reg;
  assign cmd_code    = code_reg;
  assign err_count   = err_reg;

endmodule

// File: tb/tb_pong_cmd_decoder.sv
// Self-checking bench for pong_cmd_decoder: directed packets from the test list
// plus randomized packet traffic, checked every cycle against a packet-level model.
module tb_pong_cmd_decoder;

  localparam int Y_W   = 10;
  localparam int PMIN  = 0;
  localparam int PMAX  = 420;
  localparam int PINIT = 210;
  localparam int TMO   = 200;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     rx_data;
  logic           rx_ready;
  logic [Y_W-1:0] paddle_y;
  logic           serve_pulse;
  logic           paused;
  logic           cmd_valid;
  logic [7:0]     cmd_code;
  logic [7:0]     err_count;

  pong_cmd_decoder #(
    .Y_W(Y_W), .PADDLE_MIN(PMIN), .PADDLE_MAX(PMAX),
    .PADDLE_INIT(PINIT), .TIMEOUT(TMO)
  ) dut (
    .bounderClock(clk),
    .reset(rst),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .paddle_y(paddle_y),
    .serve_pulse(serve_pulse),
    .paused(paused),
    .cmd_valid(cmd_valid),
    .cmd_code(cmd_code),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int serve_seen = 0;
  bit check_en = 1'b0;

  // Packet-level reference: bytes collected in a queue, actions by command code.
  int         m_paddle;
  bit         m_paused, m_serve, m_valid;
  int         m_code, m_err;
  logic [7:0] pkt[$];
  int         cyc = 0;
  int         last_take, exec_at;
  logic [7:0] exec_cmd, exec_arg;
  bit         prev_ready;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_paddle = PINIT; m_paused = 0; m_serve = 0; m_valid = 0;
    m_code = 0; m_err = 0; pkt.delete(); exec_at = -1; prev_ready = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    cyc++;
    m_serve = 0;
    m_valid = 0;
    if (exec_at == cyc) begin
      int p;
      p = m_paddle;
      case (exec_cmd)
        8'h55: begin p = p - int'(exec_arg); if (p < PMIN) p = PMIN; end
        8'h44: begin p = p + int'(exec_arg); if (p > PMAX) p = PMAX; end
        8'h43: p = PINIT;
        8'h53: m_serve = 1;
        8'h50: m_paused = !m_paused;
        default: ;
      endcase
      if (exec_cmd inside {8'h55, 8'h44, 8'h43, 8'h53, 8'h50}) begin
        m_paddle = p; m_valid = 1; m_code = int'(exec_cmd);
      end else begin
        m_err = sat(m_err);
      end
    end
    if (prev_ready) begin
      last_take = cyc;
      if (pkt.size() == 0) begin
        if (rx_data == 8'hA5) pkt.push_back(rx_data);
      end else begin
        pkt.push_back(rx_data);
        if (pkt.size() == 4) begin
          if (pkt[3] == (pkt[1] ^ pkt[2])) begin
            exec_cmd = pkt[1]; exec_arg = pkt[2]; exec_at = cyc + 1;
          end else begin
            m_err = sat(m_err);
          end
          pkt.delete();
        end
      end
    end else if (pkt.size() != 0 && cyc - last_take == TMO + 1) begin
      m_err = sat(m_err);
      pkt.delete();
    end
    prev_ready = rx_ready;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("paddle_y", int'(paddle_y), m_paddle);
      chk("serve_pulse", int'(serve_pulse), int'(m_serve));
      chk("paused", int'(paused), int'(m_paused));
      chk("cmd_valid", int'(cmd_valid), int'(m_valid));
      chk("cmd_code", int'(cmd_code), m_code);
      chk("err_count", int'(err_count), m_err);
      if (serve_pulse) serve_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Strobe with junk on the bus, then present the byte from the next cycle on.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_ready = 1'b1; rx_data = 8'($urandom);
    tick();
    rx_ready = 1'b0; rx_data = b;
    tick();
    repeat (gap) tick();
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
    send_byte(8'hA5, 3); send_byte(c, 3); send_byte(a, 3); send_byte(k, 4);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_paddle", int'(paddle_y), PINIT);
    chk("rst_err", int'(err_count), 0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int s0, e0, g;
    logic [7:0] c, a, k;
    logic [7:0] cmds [6];
    cmds = '{8'h55, 8'h44, 8'h43, 8'h53, 8'h50, 8'h00};
    rst = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
    model_reset();
    #1;
    check_en = 1'b1;
    do_reset();

    send_pkt(8'h44, 8'h10, 8'h54);
    chk("d_paddle", int'(paddle_y), 226);
    chk("d_code", int'(cmd_code), 8'h44);
    chk("model_d_paddle", m_paddle, 226);

    send_pkt(8'h43, 8'h00, 8'h43);
    send_pkt(8'h55, 8'hFF, 8'hAA);
    chk("u_clamp_min", int'(paddle_y), 0);
    send_pkt(8'h44, 8'hFF, 8'hBB);
    chk("d_255", int'(paddle_y), 255);
    send_pkt(8'h44, 8'hFF, 8'hBB);
    send_pkt(8'h44, 8'hFF, 8'hBB);
    chk("d_clamp_max", int'(paddle_y), 420);
    chk("model_clamp_max", m_paddle, 420);

    s0 = serve_seen;
    send_pkt(8'h53, 8'h00, 8'h00);
    chk("badchk_err", int'(err_count), 1);
    chk("badchk_noserve", serve_seen - s0, 0);
    send_pkt(8'h58, 8'h01, 8'h59);
    chk("unknown_err", int'(err_count), 2);
    chk("unknown_code", int'(cmd_code), 8'h44);

    send_byte(8'hA5, 3); send_byte(8'h44, 250);
    chk("timeout_err", int'(err_count), 3);
    send_pkt(8'h50, 8'h00, 8'h50);
    chk("pause_on", int'(paused), 1);
    send_pkt(8'h50, 8'h00, 8'h50);
    chk("pause_off", int'(paused), 0);

    s0 = serve_seen; e0 = int'(err_count);
    send_byte(8'h00, 3); send_byte(8'hFF, 3);
    send_pkt(8'h53, 8'h00, 8'h53);
    chk("resync_serves", serve_seen - s0, 1);
    chk("resync_err", int'(err_count), e0);

    send_byte(8'hA5, 3); send_byte(8'h44, 3);
    do_reset();
    chk("midpkt_paddle", int'(paddle_y), PINIT);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'($urandom), $urandom_range(3, 12));
      end else begin
        c = cmds[$urandom_range(0, 5)];
        if (c == 8'h00) c = 8'($urandom);
        a = 8'($urandom);
        k = c ^ a;
        if ($urandom_range(0, 7) == 0) k = k ^ 8'($urandom_range(1, 255));
        for (int j = 0; j < 4; j++) begin
          g = $urandom_range(3, 12);
          if ($urandom_range(0, 39) == 0) g = TMO - 2 + $urandom_range(0, 3);
          case (j)
            0: send_byte(8'hA5, g);
            1: send_byte(c, g);
            2: send_byte(a, g);
            default: send_byte(k, g);
          endcase
        end
      end
    end
    repeat (5) tick();
    check_en = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
